alu_op_sequencer: RTL and testbench

Sequencing controller for the shared R0 arithmetic multiplexer (add / sub / Booth multiply / negate). Accepts one operation request at a time over a valid/ready handshake and latches the operands. It then drives the multiplexer's enable, state and operand inputs and waits for a trustworthy completion, guarding against stale `ready` and hung operations with a timeout. Results are written into registered result registers R0/R1 with a one-cycle completion pulse.

---
 rtl/alu_op_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequencing controller for the shared R0 arithmetic multiplexer.
// Latches one request, drives the mux, and waits for a trustworthy completion or a timeout.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       alu_en,
  output logic [1:0] alu_state,
  output logic [7:0] alu_value1,
  output logic [7:0] alu_value2,
  input  logic [7:0] alu_out1,
  input  logic [7:0] alu_out2,
  input  logic       alu_ready,
  output logic [7:0] r0_data,
  output logic [7:0] r1_data,
  output logic       result_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic       zero
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [7:0] TLAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wcnt;
  logic       armed;
  logic       armed_now;
  logic       settled;
  logic       finish;

  // A multiply only trusts ready after having seen it low during this operation,
  // since the mux leaves ready high from the previous multiply.
  always_comb begin
    armed_now = armed | ~alu_ready;
    settled   = (wcnt >= SETTLE);
    finish    = 1'b0;
    if (settled) begin
      case (alu_state)
        OP_ADD, OP_SUB: finish = alu_ready;
        OP_MUL:         finish = armed_now & alu_ready;
        OP_NEG:         finish = 1'b1;
        default:        finish = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      alu_en       <= 1'b0;
      alu_state    <= 2'd0;
      alu_value1   <= 8'd0;
      alu_value2   <= 8'd0;
      r0_data      <= 8'd0;
      r1_data      <= 8'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      zero         <= 1'b1;
      wcnt         <= 8'd0;
      armed        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            alu_state   <= req_op;
            alu_value1  <= req_a;
            alu_value2  <= req_b;
            wcnt        <= 8'd0;
            armed       <= 1'b0;
            timeout_err <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            alu_en      <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion takes priority over the timeout on the same edge.
          if (finish) begin
            r0_data      <= alu_out1;
            if (alu_state == OP_MUL) begin
              r1_data <= alu_out2;
              zero    <= (alu_out1 == 8'd0) && (alu_out2 == 8'd0);
            end else begin
              zero    <= (alu_out1 == 8'd0);
            end
            alu_en       <= 1'b0;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else if (wcnt == TLAST) begin
            timeout_err  <= 1'b1;
            alu_en       <= 1'b0;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            wcnt  <= wcnt + 8'd1;
            armed <= armed_now;
          end
        end
        S_DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          req_ready    <= 1'b1;
          state        <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          req_ready    <= 1'b1;
          alu_en       <= 1'b0;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected results, a monitor pops on result_valid.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_b;
  logic       alu_en;
  logic [1:0] alu_state;
  logic [7:0] alu_value1, alu_value2;
  logic [7:0] alu_out1, alu_out2;
  logic       alu_ready;
  logic [7:0] r0_data, r1_data;
  logic       result_valid, busy, timeout_err, zero;

  logic [7:0] d_out1, d_out2;
  logic       mdl;
  logic [15:0] prod;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b, r0, r1;
    logic       zero, tmo;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   accq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_en(alu_en), .alu_state(alu_state),
    .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_ready(alu_ready),
    .r0_data(r0_data), .r1_data(r1_data),
    .result_valid(result_valid), .busy(busy),
    .timeout_err(timeout_err), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the multiplexer, used only in the back-to-back run.
  always_comb begin
    prod     = alu_value1 * alu_value2;
    alu_out1 = d_out1;
    alu_out2 = d_out2;
    if (mdl) begin
      case (alu_state)
        2'd0:    alu_out1 = alu_value1 + alu_value2;
        2'd1:    alu_out1 = alu_value1 - alu_value2;
        2'd2:    alu_out1 = prod[15:8];
        default: alu_out1 = 8'd0 - alu_value1;
      endcase
      alu_out2 = prod[7:0];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input logic z, input logic tmo, input int lat);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.r0 = r0; e.r1 = r1; e.zero = z; e.tmo = tmo; e.lat = lat;
    return e;
  endfunction

  // Presents a request and returns #1 after its accepting edge.
  task automatic issue(input exp_t e, input bit hold, input bit push, output int acc);
    bit got = 0;
    acc = -1;
    req_op = e.op; req_a = e.a; req_b = e.b; req_valid = 1'b1;
    if (push) q.push_back(e);
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      if (req_ready) begin got = 1; acc = cyc; end
    end
    #1;
    if (!hold) req_valid = 1'b0;
    if (!got) chk("accept_wait", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      chk("drain_wait", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_alu_en"}, alu_en, 0);
    chk({tag, "_alu_ops"}, {alu_state, alu_value1, alu_value2}, 0);
    chk({tag, "_r0r1"}, {r0_data, r1_data}, 0);
    chk({tag, "_flags"}, {result_valid, busy, timeout_err, zero}, 4'b0001);
  endtask

  // Monitor: latency, operand stability, handshake and result checks.
  always begin
    bit acc_now;
    @(posedge clk);
    acc_now = !rst && req_valid && req_ready;
    if (rst) accq.delete();
    else if (acc_now) accq.push_back(cyc);
    #1;
    if (acc_now) chk("accept_flags", {req_ready, busy, timeout_err, alu_en}, 4'b0101);
    if (busy) chk("ready_low_busy", req_ready, 0);
    if (alu_en && q.size() > 0)
      chk("operands_stable", {alu_state, alu_value1, alu_value2}, {q[0].op, q[0].a, q[0].b});
    if (result_valid) begin
      if (q.size() == 0) chk("spurious_result", 1, 0);
      else begin
        exp_t e;
        int   a0;
        e  = q.pop_front();
        a0 = (accq.size() > 0) ? accq.pop_front() : -1000;
        chk("latency", cyc - a0, e.lat);
        chk("r0", r0_data, e.r0);
        chk("r1", r1_data, e.r1);
        chk("zero", zero, e.zero);
        chk("timeout_err", timeout_err, e.tmo);
        chk("busy_done", {busy, alu_en}, 2'b10);
      end
    end
  end

  initial begin
    int a1, a2;
    rst = 1'b1; req_valid = 1'b0; req_op = 0; req_a = 0; req_b = 0;
    d_out1 = 0; d_out2 = 0; alu_ready = 1'b0; mdl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // ADD 100+27
    alu_ready = 1'b1; d_out1 = 8'd127;
    issue(mk(2'd0, 8'd100, 8'd27, 8'd127, 8'd0, 1'b0, 1'b0, 2), 0, 1, a1);
    drain();

    // MUL 12*11 = 0x0084 with a stale ready at entry
    alu_ready = 1'b1; d_out1 = 8'h00; d_out2 = 8'h84;
    issue(mk(2'd2, 8'd12, 8'd11, 8'h00, 8'h84, 1'b0, 1'b0, 6), 0, 1, a1);
    repeat (2) @(posedge clk);
    #1 alu_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 alu_ready = 1'b1;
    drain();

    // NEG 5 with ready stuck low
    alu_ready = 1'b0; d_out1 = 8'hFB;
    issue(mk(2'd3, 8'd5, 8'd9, 8'hFB, 8'h84, 1'b0, 1'b0, 2), 0, 1, a1);
    drain();

    // SUB 5-5 gives a zero result
    alu_ready = 1'b1; d_out1 = 8'h00;
    issue(mk(2'd1, 8'd5, 8'd5, 8'h00, 8'h84, 1'b1, 1'b0, 2), 0, 1, a1);
    drain();

    // SUB that never completes: timeout, registers unchanged
    alu_ready = 1'b0; d_out1 = 8'h55;
    issue(mk(2'd1, 8'd9, 8'd3, 8'h00, 8'h84, 1'b1, 1'b1, 32), 0, 1, a1);
    drain();

    // Next request clears the sticky timeout
    alu_ready = 1'b1; d_out1 = 8'd3;
    issue(mk(2'd0, 8'd1, 8'd2, 8'd3, 8'h84, 1'b0, 1'b0, 2), 0, 1, a1);
    drain();

    // Reset during WAIT (wcnt=2) of a MUL: no result, back to reset values
    alu_ready = 1'b0;
    issue(mk(2'd2, 8'd3, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 0), 0, 0, a1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("midwait_rst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back ADD then SUB with req_valid held
    mdl = 1'b1; alu_ready = 1'b1;
    issue(mk(2'd0, 8'd20, 8'd30, 8'd50, 8'd0, 1'b0, 1'b0, 2), 1, 1, a1);
    issue(mk(2'd1, 8'd50, 8'd8, 8'd42, 8'd0, 1'b0, 1'b0, 2), 0, 1, a2);
    chk("b2b_gap", a2 - a1, 4);
    drain();

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
